fp_divider: RTL
===============

Name: fp_divider

Overview:
- Iterative IEEE-754 floating-point divider. Computes op_a / op_b.
- Sits beside fp_multiplier in the FP execute cluster and uses the same operand, mode and flag conventions.
- It has the same external valid/ready interface, so the issue logic can steer an operation to either unit unchanged.
- It uses a multicycle restoring quotient engine in place of a pipeline: one operation is in flight at a time.

Parameters:
- QBITS, 26, number of quotient bits developed: 24 mantissa bits, 1 guard bit, 1 extra bit for normalization.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- op_a  in  32  dividend; half-precision value in [15:0] when mode_fp=0
- op_b  in  32  divisor; same layout as op_a
- mode_fp  in  1  0 = half-precision operands, 1 = single-precision operands
- round_mode  in  1  0 = round toward zero, 1 = round to nearest even
- start  in  1  upstream valid
- ready_in  in  1  downstream ready
- valid_out  out  1  result valid
- ready_out  out  1  divider can accept an operation
- result  out  32  IEEE single-precision quotient
- flags  out  5  [4]=DZ, [3]=NV, [2]=OF, [1]=UF, [0]=NX

Behaviour:
- Reset: state=IDLE. valid_out=0, result=0, flags=0, ready_out=1. Reset mid-operation discards the operation with no output.
- Decode:
  - Half operands are widened: exponent plus 112, mantissa << 13.
  - Output is always single precision.
  - An exponent of 0 is treated as zero (subnormal inputs flush to zero, keeping their sign).
- Handshake:
  - ready_out = (state==IDLE) || (state==DONE && ready_in).
  - An operation is accepted on start && ready_out. Operands are sampled only at acceptance.
  - Accepting in DONE while the current result is consumed is legal and gives back-to-back operation.
  - start is ignored while ready_out=0.
- Special cases are resolved at acceptance. The FSM goes straight to DONE, with valid_out=1 on the next edge (latency 1):
  - Either operand NaN -> 0x7FC00000, NV.
  - 0/0 or inf/inf -> 0xFFC00000, NV.
  - inf/finite -> signed inf, no flags.
  - finite/inf -> signed zero, no flags.
  - nonzero finite/0 -> signed inf, DZ.
  - 0/nonzero -> signed zero, no flags.
  - Sign of signed results = sign_a ^ sign_b.
- State IDLE -> DIV (normal case):
  - Load 25-bit remainder r={0,1.ma} and divisor d={0,1.mb}.
  - Load 10-bit signed exponent e=ea-eb+127; iteration counter=0.
- State DIV: one quotient bit per cycle, MSB first.
  - If r>=d: qbit=1 and r=(r-d)<<1; otherwise qbit=0 and r=r<<1.
  - After QBITS cycles go to NORM.
- State NORM (one cycle):
  - If q[25]=1: mant=q[25:2], G=q[1], S=q[0]|(r!=0).
  - Else: mant=q[24:1], G=q[0], S=(r!=0), and e=e-1.
  - Rounding when round_mode=1: increment if G&&(S||mant[0]). No increment when round_mode=0.
  - A rounding carry out of the mantissa gives mant=0x800000 and e=e+1.
  - NX=G|S.
  - e>=255 -> signed inf, flags OF|NX.
  - e<=0 -> signed zero, flags UF|NX.
  - Otherwise result={sign, e[7:0], mant[22:0]}.
  - Register the result and flags, then go to DONE.
- Latency, normal path: valid_out rises 28 clock edges after the acceptance edge (1 load + 26 DIV + 1 NORM).
- State DONE:
  - valid_out=1; result and flags are held stable until valid_out && ready_in.
  - On that handshake: go to DIV/DONE if a new operation is accepted in the same cycle, else to IDLE with valid_out=0.
- Outputs are registered. result and flags keep their last value after valid_out falls.

Test Plan:
- 6.0/2.0 (0x40C00000/0x40000000), mode_fp=1, ready_in=1 -> result 0x40400000, flags 00000, valid_out 28 edges after accept for exactly 1 cycle.
- 1.0/3.0 (0x3F800000/0x40400000) -> round_mode=1 gives 0x3EAAAAAB; round_mode=0 gives 0x3EAAAAAA; flags 00001 in both.
- Specials, each with latency 1:
  - 0x3F800000/0x00000000 -> 0x7F800000, flags 10000.
  - 0/0 -> 0xFFC00000, flags 01000.
  - NaN/1.0 -> 0x7FC00000, flags 01000.
  - 0x80000000/0x40000000 -> 0x80000000, flags 00000.
- Half mode: op_a=0x00004600 (6.0), op_b=0x00004000 (2.0), mode_fp=0 -> 0x40400000, flags 00000.
- Range limits:
  - 0x7F000000/0x3E800000 -> 0x7F800000, flags 00101.
  - 0x00800000/0x7F000000 -> 0x00000000, flags 00011.
- Flow control:
  - ready_in low for 10 cycles in DONE -> result stable, ready_out=0, start pulses ignored; raising ready_in with start high accepts the next operation back-to-back.
  - rst_n low mid-DIV -> valid_out=0 and ready_out=1 immediately, and no stale result afterwards.

Source files
------------

// File: rtl/fp_divider.sv
// ============================================================================
// fp_divider : iterative IEEE-754 divider (half/single in, single out),
//              restoring quotient engine, valid/ready handshake.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fp_divider #(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mode_fp,
    input  logic        round_mode,
    input  logic        start,
    input  logic        ready_in,
    output logic        valid_out,
    output logic        ready_out,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    localparam int CNT_W = $clog2(QBITS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Re-express a half operand in single-precision layout so one decoder serves both.
    function automatic logic [31:0] widen(input logic [31:0] op, input logic fp32);
        logic [4:0] e5;
        e5 = op[14:10];
        if (fp32)
            widen = op;
        else if (e5 == 5'd0)
            widen = {op[15], 8'h00, op[9:0], 13'd0};
        else if (e5 == 5'h1F)
            widen = {op[15], 8'hFF, op[9:0], 13'd0};
        else
            widen = {op[15], {3'b000, e5} + 8'd112, op[9:0], 13'd0};
    endfunction

    logic [1:0]        state_q, state_d;
    logic [24:0]       r_q, r_d;
    logic [23:0]       d_q, d_d;
    logic [QBITS-1:0]  q_q, q_d;
    logic signed [9:0] e_q, e_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              rm_q, rm_d;
    logic [31:0]       result_q, result_d;
    logic [4:0]        flags_q, flags_d;

    // ------------------------------------------------------------------ decode
    logic [31:0] wa, wb;
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [9:0] e_load;

    assign wa     = widen(op_a, mode_fp);
    assign wb     = widen(op_b, mode_fp);
    assign sa     = wa[31];
    assign sb     = wb[31];
    assign ea     = wa[30:23];
    assign eb     = wb[30:23];
    assign ma     = wa[22:0];
    assign mb     = wb[22:0];
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (ma == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (mb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (ma != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (mb != 23'd0);
    assign e_load = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

    logic        spec_hit;
    logic [31:0] spec_res;
    logic [4:0]  spec_flg;
    logic        sq;

    assign sq = sa ^ sb;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = 32'd0;
        spec_flg = 5'd0;
        if (a_nan || b_nan) begin
            spec_res = 32'h7FC0_0000;
            spec_flg = 5'b01000;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = 32'hFFC0_0000;
            spec_flg = 5'b01000;
        end else if (a_inf) begin
            spec_res = {sq, 8'hFF, 23'd0};
        end else if (b_inf) begin
            spec_res = {sq, 31'd0};
        end else if (b_zero) begin
            spec_res = {sq, 8'hFF, 23'd0};
            spec_flg = 5'b10000;
        end else if (a_zero) begin
            spec_res = {sq, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ---------------------------------------------------------------- handshake
    logic accept;

    assign ready_out = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_in);
    assign accept    = start && ready_out;

    // ------------------------------------------------------------ divide step
    logic        r_ge;
    logic [23:0] r_sub;

    // r - d always fits in 24 bits whenever r >= d, since the difference is below d.
    assign r_ge  = (r_q >= {1'b0, d_q});
    assign r_sub = r_q[23:0] - d_q;

    // --------------------------------------------------------- normalise/round
    logic              hi, g_bit, s_bit, inc, carry, nx;
    logic [22:0]       frac, frac_r;
    logic signed [9:0] e_adj, e_fin;
    logic [31:0]       norm_res;
    logic [4:0]        norm_flg;

    assign hi    = q_q[QBITS-1];
    assign frac  = hi ? q_q[QBITS-2:2] : q_q[QBITS-3:1];
    assign g_bit = hi ? q_q[1] : q_q[0];
    assign s_bit = (hi & q_q[0]) | (r_q != 25'd0);
    assign inc   = rm_q & g_bit & (s_bit | frac[0]);
    assign {carry, frac_r} = {1'b0, frac} + {23'd0, inc};
    assign e_adj = hi ? e_q : e_q - 10'sd1;
    assign e_fin = e_adj + $signed({9'd0, carry});
    assign nx    = g_bit | s_bit;

    always_comb begin
        if (e_fin >= 10'sd255) begin
            norm_res = {sign_q, 8'hFF, 23'd0};
            norm_flg = 5'b00101;
        end else if (e_fin <= 10'sd0) begin
            norm_res = {sign_q, 31'd0};
            norm_flg = 5'b00011;
        end else begin
            norm_res = {sign_q, e_fin[7:0], frac_r};
            norm_flg = {4'b0000, nx};
        end
    end

    // ------------------------------------------------------------------- FSM
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        d_d      = d_q;
        q_d      = q_q;
        e_d      = e_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        rm_d     = rm_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            S_DIV: begin
                r_d   = r_ge ? {r_sub, 1'b0} : {r_q[23:0], 1'b0};
                q_d   = {q_q[QBITS-2:0], r_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(QBITS - 1))
                    state_d = S_NORM;
            end
            S_NORM: begin
                result_d = norm_res;
                flags_d  = norm_flg;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (ready_in)
                    state_d = S_IDLE;
            end
            default: ;
        endcase

        // Acceptance overrides the DONE->IDLE exit, giving back-to-back issue.
        if (accept) begin
            sign_d = sq;
            rm_d   = round_mode;
            if (spec_hit) begin
                result_d = spec_res;
                flags_d  = spec_flg;
                state_d  = S_DONE;
            end else begin
                r_d     = {2'b01, ma};
                d_d     = {1'b1, mb};
                q_d     = '0;
                e_d     = e_load;
                cnt_d   = '0;
                state_d = S_DIV;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            d_q      <= '0;
            q_q      <= '0;
            e_q      <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            rm_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            d_q      <= d_d;
            q_q      <= q_d;
            e_q      <= e_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            rm_q     <= rm_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign valid_out = (state_q == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

`default_nettype wire
